// File: rtl/avalon_rom_slave.sv
// Avalon-MM read-only slave: single outstanding read, fixed LATENCY, one readdatavalid pulse.
// Optional macro AVS_RESP_EN adds avs_response and a DEADBEEF pattern for out-of-range reads.
module avalon_rom_slave #(
  parameter int DEPTH     = 9,
  parameter int LATENCY   = 4,
  parameter     INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] avs_address,
  input  logic        avs_read,
  output logic [63:0] avs_readdata,
  output logic        avs_readdatavalid,
  output logic        avs_waitrequest,
`ifdef AVS_RESP_EN
  output logic [1:0]  avs_response,
`endif
  output logic [1:0]  dbg_state
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Counter only ever holds LATENCY-2 down to 0.
  localparam int CW = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;

`ifdef AVS_RESP_EN
  localparam logic [63:0] OOR_DATA = 64'hDEAD_BEEF_DEAD_BEEF;
`else
  localparam logic [63:0] OOR_DATA = 64'h0;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            oor_q, oor_d;
  logic [63:0]     rom_word;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    oor_d   = oor_q;
    unique case (state_q)
      S_IDLE: begin
        if (avs_read) begin
          addr_d = avs_address[AW-1:0];
          oor_d  = (avs_address >= 32'(DEPTH));
          if (LATENCY == 1) begin
            state_d = S_RESP;
          end else begin
            state_d = S_BUSY;
            cnt_d   = CW'(LATENCY - 2);
          end
        end
      end
      S_BUSY: begin
        if (cnt_q == '0) state_d = S_RESP;
        else             cnt_d   = cnt_q - CW'(1);
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      oor_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      oor_q   <= oor_d;
    end
  end

  // Byte j of word i is (8*i + j) mod 256.
  always_comb begin
    rom_word = '0;
    for (int j = 0; j < 8; j++) begin
      rom_word[8*j +: 8] = 8'({addr_q, 3'b000}) + 8'(j);
    end
  end

  // All outputs decode registered state only; avs_read never reaches an output combinationally.
  assign avs_waitrequest   = (state_q != S_IDLE);
  assign avs_readdatavalid = (state_q == S_RESP);
  assign avs_readdata      = !avs_readdatavalid ? 64'h0 : (oor_q ? OOR_DATA : rom_word);
  assign dbg_state         = state_q;
`ifdef AVS_RESP_EN
  assign avs_response      = (avs_readdatavalid && oor_q) ? 2'b10 : 2'b00;
`endif

endmodule
